// File: rtl/wishbone_read_master.sv
// -----------------------------------------------------------------------------
// wishbone_read_master
//
// Wishbone classic initiator. Takes one little-endian request at a time from
// the core, runs it as a big-endian bus cycle and returns exactly one response.
// Retry terminations are re-issued in-block after a one-cycle backoff. Retry
// exhaustion, error terminations and (optionally) timeouts all come back as
// a response with rsp_err_o set.
//
// Optional feature: define WB_MASTER_TIMEOUT_EN to abort a bus cycle after
// TIMEOUT_CYCLES strobe cycles that see no termination. When it is not defined,
// the block waits in BUS indefinitely.
//
// Parameters:
//   MAX_RETRIES     re-issues allowed after rty_i (0 = first rty_i is an error)
//   TIMEOUT_CYCLES  strobe cycles before abort (1..255, timeout build only)
//
// Ports:
//   clk_i, rst_ni                clock, asynchronous active-low reset
//   req_valid_i / req_ready_o    request handshake
//   req_addr_i, req_we_i,
//   req_sel_i, req_wdata_i       request payload (little-endian)
//   rsp_valid_o / rsp_ready_i    response handshake
//   rsp_rdata_o, rsp_err_o       response payload (little-endian)
//   cyc_o, stb_o, we_o, adr_o,
//   sel_o, dat_o                 Wishbone outputs (big-endian lanes)
//   dat_i, ack_i, err_i, rty_i   Wishbone inputs
//   dbg_state                    current FSM state (IDLE=0 BUS=1 BACKOFF=2 RESP=3)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Valid, once raised, stays high with a stable payload until that
// edge; ready may change freely.
// -----------------------------------------------------------------------------
module wishbone_read_master #(
   parameter int MAX_RETRIES    = 3,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   input  logic        req_we_i,
   input  logic [3:0]  req_sel_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        cyc_o,
   output logic        stb_o,
   output logic        we_o,
   output logic [31:0] adr_o,
   output logic [3:0]  sel_o,
   output logic [31:0] dat_o,
   input  logic [31:0] dat_i,
   input  logic        ack_i,
   input  logic        err_i,
   input  logic        rty_i,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUS     = 2'd1,
      BACKOFF = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t     state;
   logic       we_lat;     // we_o is forced low outside BUS, so keep the request's we here
   logic [7:0] retry_cnt;
   logic       tmo_hit;
   logic       unused_bits;

   assign dbg_state = state;

   function automatic logic [31:0] swap32(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   function automatic logic [3:0] swap4(input logic [3:0] s);
      return {s[0], s[1], s[2], s[3]};
   endfunction

`ifdef WB_MASTER_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] tmo_cnt;

   // Held at zero outside BUS, so every entry to BUS (first issue or retry)
   // starts a fresh count. The count equals the number of termination-free
   // BUS cycles already seen; the abort fires on the TIMEOUT_CYCLES-th one.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_cnt <= 8'd0;
      end else if (state != BUS) begin
         tmo_cnt <= 8'd0;
      end else if (!(err_i || ack_i || rty_i)) begin
         tmo_cnt <= tmo_cnt + 8'd1;
      end
   end

   assign tmo_hit     = (tmo_cnt == TMO_LAST);
   assign unused_bits = ^req_addr_i[1:0];
`else
   assign tmo_hit     = 1'b0;
   assign unused_bits = ^req_addr_i[1:0] ^ (TIMEOUT_CYCLES == 0);
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         req_ready_o <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= 32'd0;
         rsp_err_o   <= 1'b0;
         cyc_o       <= 1'b0;
         stb_o       <= 1'b0;
         we_o        <= 1'b0;
         adr_o       <= 32'd0;
         sel_o       <= 4'd0;
         dat_o       <= 32'd0;
         we_lat      <= 1'b0;
         retry_cnt   <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               req_ready_o <= 1'b1;
               if (req_valid_i && req_ready_o) begin
                  adr_o       <= {req_addr_i[31:2], 2'b00};
                  sel_o       <= swap4(req_sel_i);
                  dat_o       <= swap32(req_wdata_i);
                  we_lat      <= req_we_i;
                  we_o        <= req_we_i;
                  cyc_o       <= 1'b1;
                  stb_o       <= 1'b1;
                  retry_cnt   <= 8'd0;
                  req_ready_o <= 1'b0;
                  state       <= BUS;
               end
            end

            BUS: begin
               if (err_i) begin
                  cyc_o       <= 1'b0;
                  stb_o       <= 1'b0;
                  we_o        <= 1'b0;
                  rsp_err_o   <= 1'b1;
                  rsp_rdata_o <= 32'd0;
                  rsp_valid_o <= 1'b1;
                  state       <= RESP;
               end else if (ack_i) begin
                  cyc_o       <= 1'b0;
                  stb_o       <= 1'b0;
                  we_o        <= 1'b0;
                  rsp_err_o   <= 1'b0;
                  rsp_rdata_o <= we_lat ? 32'd0 : swap32(dat_i);
                  rsp_valid_o <= 1'b1;
                  state       <= RESP;
               end else if (rty_i) begin
                  cyc_o <= 1'b0;
                  stb_o <= 1'b0;
                  we_o  <= 1'b0;
                  if (int'(retry_cnt) < MAX_RETRIES) begin
                     retry_cnt <= retry_cnt + 8'd1;
                     state     <= BACKOFF;
                  end else begin
                     rsp_err_o   <= 1'b1;
                     rsp_rdata_o <= 32'd0;
                     rsp_valid_o <= 1'b1;
                     state       <= RESP;
                  end
               end else if (tmo_hit) begin
                  cyc_o       <= 1'b0;
                  stb_o       <= 1'b0;
                  we_o        <= 1'b0;
                  rsp_err_o   <= 1'b1;
                  rsp_rdata_o <= 32'd0;
                  rsp_valid_o <= 1'b1;
                  state       <= RESP;
               end
            end

            // One dead bus cycle, then re-issue the latched request unchanged.
            BACKOFF: begin
               cyc_o <= 1'b1;
               stb_o <= 1'b1;
               we_o  <= we_lat;
               state <= BUS;
            end

            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  req_ready_o <= 1'b1;
                  state       <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wishbone_read_master.sv
// -----------------------------------------------------------------------------
// tb_wishbone_read_master
//
// Bench for wishbone_read_master. A scripted responder answers each strobe
// with a per-attempt wait and termination; a transaction-level model turns
// the request and script into the expected response, strobe count, strobe
// cycles and latency, and pushes them into exp_q. A monitor compares bus
// fields every cycle and pops exp_q whenever a new response appears.
// -----------------------------------------------------------------------------
module tb_wishbone_read_master;

   localparam int MAX_RETRIES    = 3;
   localparam int TIMEOUT_CYCLES = 8;

   // termination codes for the responder script
   localparam int C_NONE   = 0;
   localparam int C_ACK    = 1;
   localparam int C_ERR    = 2;
   localparam int C_RTY    = 3;
   localparam int C_ERRACK = 4;
   localparam int C_ACKRTY = 5;

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [31:0] req_addr_i = '0;
   logic        req_we_i = 1'b0;
   logic [3:0]  req_sel_i = '0;
   logic [31:0] req_wdata_i = '0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        cyc_o, stb_o, we_o;
   logic [31:0] adr_o;
   logic [3:0]  sel_o;
   logic [31:0] dat_o;
   logic [31:0] dat_i = '0;
   logic        ack_i = 1'b0, err_i = 1'b0, rty_i = 1'b0;
   logic [1:0]  dbg_state;

   wishbone_read_master #(
      .MAX_RETRIES(MAX_RETRIES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr_i), .req_we_i(req_we_i),
      .req_sel_i(req_sel_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
      .adr_o(adr_o), .sel_o(sel_o), .dat_o(dat_o),
      .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i),
      .dbg_state(dbg_state)
   );

   // ---------------- scoreboard state ----------------
   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
      logic [15:0] lat;
      logic [7:0]  strobes;
      logic [15:0] stb_cycles;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   fails  = 0;

   int          cyc_n = 0;
   int          acc_cyc = 0;
   int          stb_cnt = 0;
   int          strobe_cnt = 0;
   logic        prev_stb = 1'b0;
   logic        in_rsp = 1'b0;
   logic        held_err = 1'b0;
   logic [31:0] held_data = '0;
   int          hold_req = 0;
   int          hold_left = 0;

   logic        exp_we = 1'b0;
   logic [31:0] exp_adr = '0;
   logic [3:0]  exp_sel = '0;
   logic [31:0] exp_dat = '0;

   // responder script
   int          att_code[8];
   int          att_wait[8];
   logic [31:0] att_data[8];
   int          n_att = 0;
   int          cur_att = 0;
   int          stb_cyc = 0;
   logic        noise_en = 1'b1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // byte lane i of the core becomes lane 3-i of the bus
   function automatic logic [31:0] rev_bytes(input logic [31:0] d);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) r[8*(3-i) +: 8] = d[8*i +: 8];
      return r;
   endfunction

   function automatic logic [3:0] rev_sel(input logic [3:0] s);
      logic [3:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) r[3-i] = s[i];
      return r;
   endfunction

   always @(posedge clk_i) cyc_n++;

   // ---------------- responder ----------------
   always @(negedge clk_i) begin
      ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
      dat_i = $urandom;
      if (stb_o) begin
         if (cur_att < n_att && stb_cyc == att_wait[cur_att]) begin
            case (att_code[cur_att])
               C_ACK:    begin ack_i = 1'b1; dat_i = att_data[cur_att]; end
               C_ERR:    err_i = 1'b1;
               C_RTY:    rty_i = 1'b1;
               C_ERRACK: begin err_i = 1'b1; ack_i = 1'b1; end
               C_ACKRTY: begin ack_i = 1'b1; rty_i = 1'b1; dat_i = att_data[cur_att]; end
               default:  ;
            endcase
            if (att_code[cur_att] != C_NONE) cur_att++;
            stb_cyc = 0;
         end else begin
            stb_cyc++;
         end
      end else begin
         stb_cyc = 0;
         // stray terminations outside a strobe must be ignored
         if (noise_en && rst_ni) {ack_i, err_i, rty_i} = 3'($urandom);
      end
   end

   // ---------------- monitor ----------------
   exp_t e_mon;
   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (stb_o) begin
            stb_cnt++;
            if (!prev_stb) strobe_cnt++;
            check("bus_fields", {cyc_o, we_o, adr_o, sel_o, dat_o},
                  {1'b1, exp_we, exp_adr, exp_sel, exp_dat});
         end else begin
            check("idle_bus", {cyc_o, we_o}, 2'b00);
         end
         prev_stb = stb_o;

         if (rsp_valid_o) begin
            if (!in_rsp) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_rsp", 1'b1, 1'b0);
               end else begin
                  e_mon = exp_q.pop_front();
                  check("rsp_err", rsp_err_o, e_mon.err);
                  check("rsp_rdata", rsp_rdata_o, e_mon.rdata);
                  check("latency", 128'(cyc_n - acc_cyc), 128'(e_mon.lat));
                  check("strobes", 128'(strobe_cnt), 128'(e_mon.strobes));
                  check("stb_cycles", 128'(stb_cnt), 128'(e_mon.stb_cycles));
               end
               in_rsp    = 1'b1;
               held_err  = rsp_err_o;
               held_data = rsp_rdata_o;
               hold_left = hold_req;
            end else begin
               check("rsp_stable", {rsp_err_o, rsp_rdata_o}, {held_err, held_data});
            end
            check("ready_low_in_rsp", req_ready_o, 1'b0);
            if (hold_left > 0) begin
               hold_left--;
               rsp_ready_i = 1'b0;
            end else begin
               rsp_ready_i = 1'($urandom_range(0, 1));
            end
            if (rsp_ready_i) in_rsp = 1'b0;
         end else begin
            rsp_ready_i = 1'($urandom_range(0, 1));
         end
      end
   end

   // ---------------- driver ----------------
   // Computes the expected outcome from the script, issues the request and
   // optionally waits for the response to drain.
   task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] wdata, input int hold, input bit wait_done);
      exp_t e;
      int   retries = 0;
      int   used = 0;
      int   stbc = 0;
      bit   done = 0;
      bit   has_rsp = 0;
      int   guard = 0;
      e = '0;
      for (int i = 0; i < n_att && !done; i++) begin
         used++;
         case (att_code[i])
            C_ERR, C_ERRACK: begin
               stbc += att_wait[i] + 1; e.err = 1'b1; e.rdata = '0; done = 1; has_rsp = 1;
            end
            C_ACK, C_ACKRTY: begin
               stbc += att_wait[i] + 1; e.err = 1'b0;
               e.rdata = we ? 32'd0 : rev_bytes(att_data[i]); done = 1; has_rsp = 1;
            end
            C_RTY: begin
               stbc += att_wait[i] + 1;
               if (retries < MAX_RETRIES) retries++;
               else begin e.err = 1'b1; e.rdata = '0; done = 1; has_rsp = 1; end
            end
            default: begin
`ifdef WB_MASTER_TIMEOUT_EN
               stbc += TIMEOUT_CYCLES; e.err = 1'b1; e.rdata = '0; has_rsp = 1;
`endif
               done = 1;
            end
         endcase
      end
      e.strobes    = 8'(used);
      e.stb_cycles = 16'(stbc);
      e.lat        = 16'(stbc + used - 1);

      @(negedge clk_i);
      req_addr_i  = addr;
      req_we_i    = we;
      req_sel_i   = sel;
      req_wdata_i = wdata;
      req_valid_i = 1'b1;
      while (!req_ready_o && guard < 2000) begin
         @(negedge clk_i);
         guard++;
      end
      if (!req_ready_o) begin
         check("req_ready_wait", 1'b0, 1'b1);
         req_valid_i = 1'b0;
         return;
      end
      exp_we   = we;
      exp_adr  = addr - (addr % 4);
      exp_sel  = rev_sel(sel);
      exp_dat  = rev_bytes(wdata);
      hold_req = hold;
      cur_att  = 0;
      @(posedge clk_i);
      #1;
      acc_cyc     = cyc_n;
      stb_cnt     = 0;
      strobe_cnt  = 0;
      req_valid_i = 1'b0;
      req_addr_i  = $urandom;
      req_we_i    = 1'($urandom);
      req_sel_i   = 4'($urandom);
      req_wdata_i = $urandom;
      if (has_rsp) exp_q.push_back(e);

      if (wait_done) begin
         guard = 0;
         while ((exp_q.size() != 0 || in_rsp) && guard < 3000) begin
            @(negedge clk_i);
            guard++;
         end
         if (exp_q.size() != 0 || in_rsp) begin
            check("rsp_wait", 1'b0, 1'b1);
            exp_q.delete();
            in_rsp = 1'b0;
         end
      end
   endtask

   task automatic set_att(input int i, input int code, input int w, input logic [31:0] d);
      att_code[i] = code;
      att_wait[i] = w;
      att_data[i] = d;
   endtask

   task automatic reset_pulse();
      #2 rst_ni = 1'b0;
      #1;
      check("reset_drop", {cyc_o, stb_o, rsp_valid_o}, 3'b000);
      check("reset_outputs", {req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, cyc_o, stb_o,
                              we_o, adr_o, sel_o, dat_o, dbg_state}, '0);
      exp_q.delete();
      in_rsp      = 1'b0;
      prev_stb    = 1'b0;
      rsp_ready_i = 1'b0;
      n_att       = 0;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      check("ready_low_before_edge", req_ready_o, 1'b0);
      @(negedge clk_i);
      check("ready_after_release", {req_ready_o, rsp_valid_o, stb_o}, 3'b100);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int last_codes[5];
      last_codes[0] = C_ACK; last_codes[1] = C_ERR; last_codes[2] = C_ERRACK;
      last_codes[3] = C_ACKRTY; last_codes[4] = C_RTY;

      #3;
      check("reset_state", {req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, cyc_o, stb_o,
                            we_o, adr_o, sel_o, dat_o, dbg_state}, '0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("ready_first_cycle", req_ready_o, 1'b1);

      // zero-wait read
      n_att = 1; set_att(0, C_ACK, 0, 32'h1122_3344);
      run_txn(1'b0, 32'h0000_0010, 4'hF, 32'h0, 0, 1);

      // byte-lane swap on write
      n_att = 1; set_att(0, C_ACK, 1, 32'h0);
      run_txn(1'b1, 32'h0000_0103, 4'b0011, 32'hAABB_CCDD, 0, 1);

      // retry exhaustion
      n_att = 5;
      for (int i = 0; i < 4; i++) set_att(i, C_RTY, 0, 32'h0);
      set_att(4, C_ACK, 0, 32'h0);
      run_txn(1'b0, 32'h0000_0200, 4'hF, 32'h0, 0, 1);

      // two retries then data
      n_att = 3;
      set_att(0, C_RTY, 0, 32'h0); set_att(1, C_RTY, 2, 32'h0);
      set_att(2, C_ACK, 1, 32'hCAFE_F00D);
      run_txn(1'b0, 32'h0000_0204, 4'hF, 32'h0, 0, 1);

      // err beats ack; response held under back-pressure
      n_att = 1; set_att(0, C_ERRACK, 0, 32'h5555_AAAA);
      run_txn(1'b0, 32'h0000_0300, 4'hF, 32'h0, 5, 1);

      // randomized traffic
      for (int t = 0; t < 40; t++) begin
         n = $urandom_range(1, 4);
         for (int i = 0; i < n - 1; i++) set_att(i, C_RTY, $urandom_range(0, 3), $urandom);
         set_att(n - 1, last_codes[$urandom_range(0, 4)], $urandom_range(0, 3), $urandom);
         set_att(n, C_ACK, $urandom_range(0, 3), $urandom);
         n_att = n + 1;
         run_txn(1'($urandom), $urandom, 4'($urandom), $urandom, $urandom_range(0, 2), 1);
      end

      // silent responder
      n_att = 1; set_att(0, C_NONE, 0, 32'h0);
`ifdef WB_MASTER_TIMEOUT_EN
      run_txn(1'b0, 32'h0000_0400, 4'hF, 32'h0, 0, 1);
      n_att = 1; set_att(0, C_NONE, 0, 32'h0);
      run_txn(1'b0, 32'h0000_0404, 4'hF, 32'h0, 0, 0);
      repeat (3) @(negedge clk_i);
`else
      run_txn(1'b0, 32'h0000_0400, 4'hF, 32'h0, 0, 0);
      repeat (1000) @(negedge clk_i);
      check("no_rsp_while_silent", rsp_valid_o, 1'b0);
`endif
      check("stb_before_reset", {cyc_o, stb_o}, 2'b11);
      reset_pulse();

      // recovery after reset
      n_att = 1; set_att(0, C_ACK, 0, 32'h0102_0304);
      run_txn(1'b0, 32'h0000_0500, 4'hF, 32'h0, 0, 1);

      repeat (3) @(negedge clk_i);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
